// File: rtl/sample_fifo_sync.sv
// sample_fifo_sync: single-clock sample FIFO on an inferred dual-port RAM.
// Define SAMPLE_FIFO_FWFT_EN for a first-word-fall-through output register.
module sample_fifo_sync #(
  parameter int DATA_LEN   = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_LEN   = $clog2(DEPTH),
  parameter int AFULL_LVL  = DEPTH - 16,
  parameter int AEMPTY_LVL = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_LEN-1:0] data_i,
  input  logic                rd_en_n,
  output logic [DATA_LEN-1:0] data_o,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDR_LEN:0]   level,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_flags
);

  localparam logic [ADDR_LEN:0]   LVL_ONE  = (ADDR_LEN+1)'(1);
  localparam logic [ADDR_LEN:0]   LVL_MAX  = (ADDR_LEN+1)'(DEPTH);
  localparam logic [ADDR_LEN:0]   LVL_AF   = (ADDR_LEN+1)'(AFULL_LVL);
  localparam logic [ADDR_LEN:0]   LVL_AE   = (ADDR_LEN+1)'(AEMPTY_LVL);
  localparam logic [ADDR_LEN-1:0] PTR_ONE  = ADDR_LEN'(1);

  logic [DATA_LEN-1:0] mem [DEPTH];

  logic [ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_LEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_LEN:0]   level_q, level_d;
  logic [DATA_LEN-1:0] data_q;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                afull_q, afull_d;
  logic                aempty_q, aempty_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                wr_ok, rd_ok, ram_rd;

`ifdef SAMPLE_FIFO_FWFT_EN
  logic valid_q, valid_d;
  logic ram_has_word;

  // level includes the word parked in the output register
  assign ram_has_word = level_q > {{ADDR_LEN{1'b0}}, valid_q};

  always_comb begin
    rd_ok   = !rd_en_n && valid_q;
    wr_ok   = wr_en && (!full_q || rd_ok);
    ram_rd  = ram_has_word && (!valid_q || rd_ok);
    valid_d = valid_q;
    if (ram_rd)     valid_d = 1'b1;
    else if (rd_ok) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end
`else
  always_comb begin
    rd_ok  = !rd_en_n && !empty_q;
    wr_ok  = wr_en && (!full_q || rd_ok);
    ram_rd = rd_ok;
  end
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok)  wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (ram_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    full_d   = (level_d == LVL_MAX);
    afull_d  = (level_d >= LVL_AF);
    aempty_d = (level_d <= LVL_AE);
`ifdef SAMPLE_FIFO_FWFT_EN
    empty_d  = !valid_d;
`else
    empty_d  = (level_d == '0);
`endif
    // an error event in the same cycle beats the clear
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_flags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en && !wr_ok)    ovf_d = 1'b1;
    if (!rd_en_n && !rd_ok) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (ram_rd) data_q <= mem[rd_ptr_q];
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign data_o       = data_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
